// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath, with a retired-instruction counter.
// Optional MEM_WAIT_EN adds a mem_ready handshake that stalls FETCH, MEMRD and MEMWR.
module mips_multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
`ifdef MEM_WAIT_EN
  input  logic             mem_ready,
`endif
  output logic             ir_write,
  output logic             pc_write,
  output logic             branch,
  output logic             mem_write,
  output logic             reg_write,
  output logic             iord,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             alu_src_a,
  output logic             pc_en,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_src,
  output logic [1:0]       alu_op,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_retired
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;
  logic             mem_rdy;

`ifdef MEM_WAIT_EN
  assign mem_rdy = mem_ready;
`else
  assign mem_rdy = 1'b1;
`endif

  always_comb begin
    state_d = S_FETCH;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:  state_d = mem_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = mem_rdy ? S_MEMWB : S_MEMRD;
      S_MEMWB:   retire  = 1'b1;
      S_MEMWR: begin
        state_d = mem_rdy ? S_FETCH : S_MEMWR;
        retire  = mem_rdy;
      end
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_RTYPEWB: retire  = 1'b1;
      S_BEQEX:   retire  = 1'b1;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_ADDIWB:  retire  = 1'b1;
      S_JEX:     retire  = 1'b1;
      default:   state_d = S_FETCH;
    endcase
    cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Moore decode of the state register; reset masks everything so no strobe leaks out.
  always_comb begin
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    branch        = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    iord          = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_src        = 2'b00;
    alu_op        = 2'b00;
    illegal_op    = 1'b0;
    state         = 4'd0;
    instr_retired = '0;
    if (!reset) begin
      state         = state_q;
      instr_retired = cnt_q;
      case (state_q)
        S_FETCH: begin
          ir_write  = mem_rdy;
          pc_write  = mem_rdy;
          alu_src_b = 2'b01;
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          case (opcode)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal_op = 1'b0;
            default:                                       illegal_op = 1'b1;
          endcase
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEMRD: iord = 1'b1;
        S_MEMWB: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
        end
        S_MEMWR: begin
          iord      = 1'b1;
          mem_write = 1'b1;
        end
        S_RTYPEEX: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        S_RTYPEWB: begin
          reg_dst   = 1'b1;
          reg_write = 1'b1;
        end
        S_BEQEX: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b01;
          pc_src    = 2'b01;
          branch    = 1'b1;
        end
        S_ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_ADDIWB: reg_write = 1'b1;
        S_JEX: begin
          pc_src   = 2'b10;
          pc_write = 1'b1;
        end
        default: ;
      endcase
    end
    pc_en = pc_write | (branch & zero);
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl (CNT_W=4 so the counter wrap is reachable).
// Each cycle's expected outputs are queued when inputs are driven and checked mid-cycle.
module tb_mips_multicycle_ctrl;

  localparam int CW = 4;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BAD   = 6'b111111;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [5:0]    opcode = 6'd0;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b1;
  logic          ir_write, pc_write, branch, mem_write, reg_write, iord;
  logic          mem_to_reg, reg_dst, alu_src_a, pc_en, illegal_op;
  logic [1:0]    alu_src_b, pc_src, alu_op;
  logic [3:0]    state;
  logic [CW-1:0] instr_retired;

  typedef struct {
    logic [3:0]    st;
    logic [14:0]   ctrl;
    logic          pce;
    logic          ill;
    logic [CW-1:0] cnt;
    string         tag;
  } exp_t;

  exp_t          sb[$];
  logic [CW-1:0] exp_cnt = '0;
  int            errors = 0;
  int            checks = 0;

  mips_multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
`ifdef MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .ir_write(ir_write), .pc_write(pc_write), .branch(branch), .mem_write(mem_write),
    .reg_write(reg_write), .iord(iord), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .alu_src_a(alu_src_a), .pc_en(pc_en), .alu_src_b(alu_src_b), .pc_src(pc_src),
    .alu_op(alu_op), .state(state), .illegal_op(illegal_op), .instr_retired(instr_retired)
  );

  always #5 clk = ~clk;

  // Bit order: ir_write pc_write branch mem_write reg_write iord mem_to_reg reg_dst
  // alu_src_a alu_src_b[1:0] pc_src[1:0] alu_op[1:0]
  function automatic logic [14:0] moore_exp(input int st);
    logic [14:0] v;
    v = '0;
    case (st)
      0:  begin v[14] = 1'b1; v[13] = 1'b1; v[5:4] = 2'b01; end
      1:  v[5:4] = 2'b11;
      2:  begin v[6] = 1'b1; v[5:4] = 2'b10; end
      3:  v[9] = 1'b1;
      4:  begin v[8] = 1'b1; v[10] = 1'b1; end
      5:  begin v[9] = 1'b1; v[11] = 1'b1; end
      6:  begin v[6] = 1'b1; v[1:0] = 2'b10; end
      7:  begin v[7] = 1'b1; v[10] = 1'b1; end
      8:  begin v[6] = 1'b1; v[1:0] = 2'b01; v[3:2] = 2'b01; v[12] = 1'b1; end
      9:  begin v[6] = 1'b1; v[5:4] = 2'b10; end
      10: v[10] = 1'b1;
      11: begin v[3:2] = 2'b10; v[13] = 1'b1; end
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic applyStimulus(input logic rst, input logic rdy, input logic [5:0] opc,
                               input logic z, input int st, input logic pce, input logic ill,
                               input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    reset     = rst;
    mem_ready = rdy;
    opcode    = opc;
    zero      = z;
    e.tag  = tag;
    e.st   = rst ? 4'd0 : 4'(st);
    e.ctrl = rst ? 15'd0 : moore_exp(st);
    if (st == 0 && !rdy) e.ctrl[14:13] = 2'b00;
    e.pce  = rst ? 1'b0 : pce;
    e.ill  = rst ? 1'b0 : ill;
    e.cnt  = rst ? '0 : exp_cnt;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t        e;
    logic [14:0] obs;
    @(negedge clk);
    e   = sb.pop_front();
    obs = {ir_write, pc_write, branch, mem_write, reg_write, iord, mem_to_reg, reg_dst,
           alu_src_a, alu_src_b, pc_src, alu_op};
    checks++;
    assert (state === e.st) else begin
      errors++;
      $error("[TB] FAIL %s state: got %0d expected %0d", e.tag, state, e.st);
    end
    checks++;
    assert (obs === e.ctrl) else begin
      errors++;
      $error("[TB] FAIL %s ctrl: got %b expected %b", e.tag, obs, e.ctrl);
    end
    checks++;
    assert (pc_en === e.pce) else begin
      errors++;
      $error("[TB] FAIL %s pc_en: got %b expected %b", e.tag, pc_en, e.pce);
    end
    checks++;
    assert (illegal_op === e.ill) else begin
      errors++;
      $error("[TB] FAIL %s illegal_op: got %b expected %b", e.tag, illegal_op, e.ill);
    end
    checks++;
    assert (instr_retired === e.cnt) else begin
      errors++;
      $error("[TB] FAIL %s instr_retired: got %0d expected %0d", e.tag, instr_retired, e.cnt);
    end
  endtask

  task automatic step(input logic rst, input logic rdy, input logic [5:0] opc, input logic z,
                      input int st, input logic pce, input logic ill, input string tag);
    applyStimulus(rst, rdy, opc, z, st, pce, ill, tag);
    checkOutput();
  endtask

  task automatic run_lw();
    step(0, 1, OP_LW, 0, 0, 1, 0, "lw_fetch");
    step(0, 1, OP_LW, 0, 1, 0, 0, "lw_decode");
    step(0, 1, OP_LW, 0, 2, 0, 0, "lw_memadr");
    step(0, 1, OP_BAD, 0, 3, 0, 0, "lw_memrd");
    step(0, 1, OP_SW, 0, 4, 0, 0, "lw_memwb");
    exp_cnt++;
  endtask

  task automatic run_sw();
    step(0, 1, OP_SW, 0, 0, 1, 0, "sw_fetch");
    step(0, 1, OP_SW, 0, 1, 0, 0, "sw_decode");
    step(0, 1, OP_SW, 0, 2, 0, 0, "sw_memadr");
    step(0, 1, OP_LW, 1, 5, 0, 0, "sw_memwr");
    exp_cnt++;
  endtask

  task automatic run_r();
    step(0, 1, OP_RTYPE, 0, 0, 1, 0, "r_fetch");
    step(0, 1, OP_RTYPE, 0, 1, 0, 0, "r_decode");
    step(0, 1, OP_RTYPE, 0, 6, 0, 0, "r_exec");
    step(0, 1, OP_RTYPE, 0, 7, 0, 0, "r_wb");
    exp_cnt++;
  endtask

  task automatic run_beq(input logic z);
    step(0, 1, OP_BEQ, z, 0, 1, 0, "beq_fetch");
    step(0, 1, OP_BEQ, z, 1, 0, 0, "beq_decode");
    step(0, 1, OP_BEQ, z, 8, z, 0, z ? "beq_taken" : "beq_not_taken");
    exp_cnt++;
  endtask

  task automatic run_addi();
    step(0, 1, OP_ADDI, 0, 0, 1, 0, "addi_fetch");
    step(0, 1, OP_ADDI, 0, 1, 0, 0, "addi_decode");
    step(0, 1, OP_ADDI, 0, 9, 0, 0, "addi_exec");
    step(0, 1, OP_ADDI, 0, 10, 0, 0, "addi_wb");
    exp_cnt++;
  endtask

  task automatic run_j();
    step(0, 1, OP_J, 0, 0, 1, 0, "j_fetch");
    step(0, 1, OP_J, 0, 1, 0, 0, "j_decode");
    step(0, 1, OP_J, 0, 11, 1, 0, "j_exec");
    exp_cnt++;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 3; i++) step(1, 1, OP_LW, 1, 0, 0, 0, "reset_hold");
    run_lw();
    run_sw();
    run_r();
    run_beq(1'b1);
    run_beq(1'b0);
    run_addi();
    step(0, 1, OP_BAD, 0, 0, 1, 0, "ill_fetch");
    step(0, 1, OP_BAD, 0, 1, 0, 1, "ill_decode");
    run_j();
    for (int i = 0; i < 16; i++) run_j();
    step(0, 1, OP_LW, 0, 0, 1, 0, "rst_lw_fetch");
    step(0, 1, OP_LW, 0, 1, 0, 0, "rst_lw_decode");
    step(0, 1, OP_LW, 0, 2, 0, 0, "rst_lw_memadr");
    step(0, 1, OP_LW, 0, 3, 0, 0, "rst_lw_memrd");
    step(1, 1, OP_LW, 0, 0, 0, 0, "rst_mid");
    exp_cnt = '0;
    run_r();
`ifdef MEM_WAIT_EN
    step(0, 0, OP_SW, 0, 0, 0, 0, "wait_fetch");
    step(0, 1, OP_SW, 0, 0, 1, 0, "wait_fetch_go");
    step(0, 1, OP_SW, 0, 1, 0, 0, "wait_decode");
    step(0, 1, OP_SW, 0, 2, 0, 0, "wait_memadr");
    for (int i = 0; i < 3; i++) step(0, 0, OP_SW, 0, 5, 0, 0, "wait_memwr");
    step(0, 1, OP_SW, 0, 5, 0, 0, "wait_memwr_go");
    exp_cnt++;
`endif
    step(0, 1, OP_J, 0, 0, 1, 0, "final_fetch");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
